mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: e_valid  in  1  E-stage instruction valid; e_addr  in  32  ALU result / byte address; e_memop  in  3  access size/sign code.
REQ-004 SHALL have ports: e_mem_read  in  1  load; e_mem_write  in  1  store; e_byteen  in  4  store byte enables from byte-enable unit; e_wdata  in  32  lane-shifted store data.
REQ-005 SHALL have ports: e_rd  in  5  destination register; e_regwrite  in  1  instruction writes rd.
REQ-006 SHALL have ports: stall_o  out  1  hold E stage; align_err  out  1  one-cycle misalignment pulse.
REQ-007 SHALL have ports: m_req  out  1; m_we  out  1; m_addr  out  32 word-aligned; m_byteen  out  4; m_wdata  out  32; m_ack  in  1; m_rdata  in  32  (data-memory bus).
REQ-008 SHALL have ports: w_valid  out  1; w_regwrite  out  1; w_rd  out  5; w_data  out  32  (to writeback).

Function
REQ-009 memop codes SHALL be: 000 word, 001 byte-unsigned, 010 byte-signed, 011 half-unsigned, 100 half-signed; others treated as word.
REQ-010 FSM SHALL have states IDLE, BUSY; accept occurs in IDLE when e_valid=1.
REQ-011 Misaligned access (word with addr[1:0]!=0, half with addr[0]=1) SHALL pulse align_err next cycle, issue no m_req, retire with w_valid=1, w_regwrite=0.
REQ-012 Aligned load/store accept SHALL enter BUSY and register m_req=1, m_addr={e_addr[31:2],2'b00}, m_we=e_mem_write, m_byteen=e_byteen for store / 4'b0000 for load, m_wdata=e_wdata.
REQ-013 In BUSY, stall_o SHALL be 1 and all m_* outputs SHALL hold stable until m_ack=1 is sampled.
REQ-014 On m_ack sample, SHALL drop m_req next cycle, return to IDLE, and pulse w_valid for one cycle; the next instruction is accepted in that IDLE cycle.
REQ-015 Load data SHALL be selected by e_addr[1:0] (byte) or e_addr[1] (half) from m_rdata, little-endian lanes, zero- or sign-extended per memop, registered into w_data on ack.
REQ-016 Stores SHALL retire with w_regwrite=0; loads with w_regwrite=e_regwrite and w_rd=e_rd.
REQ-017 Non-memory instructions SHALL pass through in one cycle: w_valid=1, w_data=e_addr, w_rd=e_rd, w_regwrite=e_regwrite; no stall.
REQ-018 stall_o SHALL be combinational from state only (BUSY); m_ack outside BUSY SHALL be ignored.
REQ-019 e_mem_read and e_mem_write both 1 SHALL be treated as store.

Reset
REQ-020 reset_n=0 SHALL immediately force state IDLE and all outputs to 0, including mid-BUSY (bus transaction abandoned).
REQ-021 First accept SHALL occur on the first rising edge with reset_n=1.

Structure
REQ-022 memop codes, state encoding and bus widths SHALL live in shared package mem_pkg, also used by the byte-enable unit.
REQ-023 Load extension SHALL be sub-module load_ext (pure combinational: rdata, addr[1:0], memop -> 32-bit result).

Verification
REQ-024 sb addr=3, e_byteen=1000, e_wdata=0x7B000000, ack 2 cycles after req -> m_addr=0, m_byteen=1000, stall_o high 3 cycles, w_valid pulse, w_regwrite=0.
REQ-025 lb addr=2, m_rdata=0x12803456 -> w_data=0xFFFFFF80; lbu same -> 0x00000080.
REQ-026 lhu addr=2, m_rdata=0xBEEF1234 -> w_data=0x0000BEEF; lh -> 0xFFFFBEEF.
REQ-027 lw addr=6 -> align_err pulse, m_req never 1, stall_o stays 0.
REQ-028 m_ack=1 on first BUSY cycle -> stall_o high exactly 1 cycle, w_valid next cycle, back-to-back load accepted immediately.
REQ-029 reset_n low mid-BUSY -> m_req, stall_o, w_valid fall same cycle; after release, next lw completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory path: memop codes, controller state
// encoding, bus widths and the alignment rule.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int RD_W   = 5;

  localparam logic [2:0] MEMOP_WORD   = 3'b000;
  localparam logic [2:0] MEMOP_BYTE_U = 3'b001;
  localparam logic [2:0] MEMOP_BYTE_S = 3'b010;
  localparam logic [2:0] MEMOP_HALF_U = 3'b011;
  localparam logic [2:0] MEMOP_HALF_S = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // Unlisted memop codes behave as word accesses, so they need 4-byte alignment.
  function automatic logic is_misaligned(input logic [2:0] memop, input logic [1:0] addr_lo);
    logic mis;
    case (memop)
      MEMOP_BYTE_U, MEMOP_BYTE_S: mis = 1'b0;
      MEMOP_HALF_U, MEMOP_HALF_S: mis = addr_lo[0];
      default:                    mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load lane select and extension: picks the addressed byte/half from a
// little-endian word and zero- or sign-extends it to 32 bits.
module load_ext
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        memop,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (memop)
      MEMOP_BYTE_U: result = {24'b0, byte_sel};
      MEMOP_BYTE_S: result = {{24{byte_sel[7]}}, byte_sel};
      MEMOP_HALF_U: result = {16'b0, half_sel};
      MEMOP_HALF_S: result = {{16{half_sel[15]}}, half_sel};
      default:      result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage memory access controller: issues one data-bus transaction per
// aligned load/store, retires all instructions to writeback.
module mem_access_ctrl
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              e_valid,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [2:0]        e_memop,
  input  logic              e_mem_read,
  input  logic              e_mem_write,
  input  logic [BE_W-1:0]   e_byteen,
  input  logic [DATA_W-1:0] e_wdata,
  input  logic [RD_W-1:0]   e_rd,
  input  logic              e_regwrite,
  output logic              stall_o,
  output logic              align_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [BE_W-1:0]   m_byteen,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              w_valid,
  output logic              w_regwrite,
  output logic [RD_W-1:0]   w_rd,
  output logic [DATA_W-1:0] w_data
);

  // Handshake: e_* is taken on a rising edge with e_valid=1 while stall_o=0.
  // m_* holds stable from the m_req rise through the edge that samples m_ack=1.

  state_e            state_q, state_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [BE_W-1:0]   m_byteen_q, m_byteen_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              align_err_q, align_err_d;
  logic              w_valid_q, w_valid_d;
  logic              w_regwrite_q, w_regwrite_d;
  logic [RD_W-1:0]   w_rd_q, w_rd_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              pend_load_q, pend_load_d;
  logic [2:0]        pend_memop_q, pend_memop_d;
  logic [1:0]        pend_lo_q, pend_lo_d;
  logic [RD_W-1:0]   pend_rd_q, pend_rd_d;
  logic              pend_rw_q, pend_rw_d;

  logic              is_mem;
  logic [DATA_W-1:0] ld_result;

  load_ext u_load_ext (
    .rdata   (m_rdata),
    .addr_lo (pend_lo_q),
    .memop   (pend_memop_q),
    .result  (ld_result)
  );

  assign is_mem = e_mem_read | e_mem_write;

  always_comb begin
    state_d      = state_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_byteen_d   = m_byteen_q;
    m_wdata_d    = m_wdata_q;
    align_err_d  = 1'b0;
    w_valid_d    = 1'b0;
    w_regwrite_d = w_regwrite_q;
    w_rd_d       = w_rd_q;
    w_data_d     = w_data_q;
    pend_load_d  = pend_load_q;
    pend_memop_d = pend_memop_q;
    pend_lo_d    = pend_lo_q;
    pend_rd_d    = pend_rd_q;
    pend_rw_d    = pend_rw_q;

    case (state_q)
      S_IDLE: begin
        if (e_valid) begin
          if (!is_mem) begin
            w_valid_d    = 1'b1;
            w_data_d     = e_addr;
            w_rd_d       = e_rd;
            w_regwrite_d = e_regwrite;
          end else if (is_misaligned(e_memop, e_addr[1:0])) begin
            align_err_d  = 1'b1;
            w_valid_d    = 1'b1;
            w_regwrite_d = 1'b0;
            w_rd_d       = e_rd;
            w_data_d     = '0;
          end else begin
            // A read+write combination is a store: no register write-back.
            state_d      = S_BUSY;
            m_req_d      = 1'b1;
            m_we_d       = e_mem_write;
            m_addr_d     = {e_addr[ADDR_W-1:2], 2'b00};
            m_byteen_d   = e_mem_write ? e_byteen : '0;
            m_wdata_d    = e_wdata;
            pend_load_d  = ~e_mem_write;
            pend_memop_d = e_memop;
            pend_lo_d    = e_addr[1:0];
            pend_rd_d    = e_rd;
            pend_rw_d    = e_regwrite;
          end
        end
      end
      S_BUSY: begin
        if (m_ack) begin
          state_d      = S_IDLE;
          m_req_d      = 1'b0;
          w_valid_d    = 1'b1;
          w_rd_d       = pend_rd_q;
          w_regwrite_d = pend_load_q & pend_rw_q;
          w_data_d     = pend_load_q ? ld_result : '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_byteen_q   <= '0;
      m_wdata_q    <= '0;
      align_err_q  <= 1'b0;
      w_valid_q    <= 1'b0;
      w_regwrite_q <= 1'b0;
      w_rd_q       <= '0;
      w_data_q     <= '0;
      pend_load_q  <= 1'b0;
      pend_memop_q <= '0;
      pend_lo_q    <= '0;
      pend_rd_q    <= '0;
      pend_rw_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_byteen_q   <= m_byteen_d;
      m_wdata_q    <= m_wdata_d;
      align_err_q  <= align_err_d;
      w_valid_q    <= w_valid_d;
      w_regwrite_q <= w_regwrite_d;
      w_rd_q       <= w_rd_d;
      w_data_q     <= w_data_d;
      pend_load_q  <= pend_load_d;
      pend_memop_q <= pend_memop_d;
      pend_lo_q    <= pend_lo_d;
      pend_rd_q    <= pend_rd_d;
      pend_rw_q    <= pend_rw_d;
    end
  end

  assign stall_o    = (state_q == S_BUSY);
  assign align_err  = align_err_q;
  assign m_req      = m_req_q;
  assign m_we       = m_we_q;
  assign m_addr     = m_addr_q;
  assign m_byteen   = m_byteen_q;
  assign m_wdata    = m_wdata_q;
  assign w_valid    = w_valid_q;
  assign w_regwrite = w_regwrite_q;
  assign w_rd       = w_rd_q;
  assign w_data     = w_data_q;

endmodule
